// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC state encoding, arctangent table and gain-compensation shifts
package cordic_pkg;
  typedef enum logic [2:0] {IDLE, PRE, ROT, POST, DONE} cordic_state_t;
  localparam int ATAN_FRAC = 4;
  localparam int GAIN_SH0 = 1;
  localparam int GAIN_SH1 = 3;
  localparam int GAIN_SH2 = 6;
  localparam int GAIN_SH3 = 9;
  function automatic logic [15:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0: return 16'd8192;
      4'd1: return 16'd4836;
      4'd2: return 16'd2555;
      4'd3: return 16'd1297;
      4'd4: return 16'd651;
      4'd5: return 16'd326;
      4'd6: return 16'd163;
      4'd7: return 16'd81;
      4'd8: return 16'd41;
      4'd9: return 16'd20;
      4'd10: return 16'd10;
      4'd11: return 16'd5;
      4'd12: return 16'd3;
      4'd13: return 16'd1;
      4'd14: return 16'd1;
      default: return 16'd0;
    endcase
  endfunction
endpackage

// File: rtl/polar_to_cmplx.sv
// polar_to_cmplx: iterative rotation-mode CORDIC turning (magnitude, phase) into (I, Q)
module polar_to_cmplx
  import cordic_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int PHASE_W = 12,
  parameter int ITER = 12
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WIDTH-1:0]   i_mag,
  input  logic [PHASE_W-1:0] i_phase,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [WIDTH-1:0]   o_i,
  output logic [WIDTH-1:0]   o_q,
  output logic               o_valid,
  input  logic               i_ready
);
  localparam int XW = WIDTH + 3;
  localparam int ZW = PHASE_W + 3;
  localparam int MW = WIDTH + 4;
  localparam int PW = WIDTH + GAIN_SH3;
  localparam int SMAX = (1 << (WIDTH - 1)) - 1;
  cordic_state_t state, state_nx;
  logic [WIDTH-2:0] mag;
  logic [PHASE_W-1:0] phase;
  logic [1:0] quad;
  logic [4:0] k;
  logic last, dir_pos;
  logic [PW-1:0] prod;
  logic signed [XW-1:0] x, y, x_sh, y_sh, x_pre;
  logic signed [ZW-1:0] z, z_pre, atan_k;
  logic signed [MW-1:0] xe, ye, mi, mq, ri, rq;

  function automatic logic [WIDTH-1:0] sat(input logic signed [MW-1:0] v);
    return v > MW'(SMAX) ? WIDTH'(SMAX) : v < MW'(-SMAX) ? WIDTH'(-SMAX) : v[WIDTH-1:0];
  endfunction

  // gain pre-compensation summed at full precision and rounded once into x's 2 fractional bits
  assign prod = (PW'(mag) << (GAIN_SH3 - GAIN_SH0)) + (PW'(mag) << (GAIN_SH3 - GAIN_SH1))
              - (PW'(mag) << (GAIN_SH3 - GAIN_SH2)) - PW'(mag) + PW'(1 << (GAIN_SH3 - 3));
  assign x_pre = XW'(prod >> (GAIN_SH3 - 2));
  // z carries one bit beyond the residual so a phase just below a quarter turn stays positive
  assign z_pre = ZW'({phase[PHASE_W-3:0], {ATAN_FRAC{1'b0}}});
  assign quad = phase[PHASE_W-1 -: 2];
  assign x_sh = x >>> k;
  assign y_sh = y >>> k;
  assign dir_pos = ~z[ZW-1];
  assign atan_k = ZW'(atan_lut(k[3:0]));
  assign last = k == 5'(ITER - 1);
  assign xe = {{(MW-XW){x[XW-1]}}, x};
  assign ye = {{(MW-XW){y[XW-1]}}, y};
  assign mi = quad == 2'd0 ? xe : quad == 2'd1 ? -ye : quad == 2'd2 ? -xe : ye;
  assign mq = quad == 2'd0 ? ye : quad == 2'd1 ? xe : quad == 2'd2 ? -ye : -xe;
  assign ri = (mi + MW'(2)) >>> 2;
  assign rq = (mq + MW'(2)) >>> 2;
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;

  // state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_nx;

  // next-state selection: one pass through PRE, ITER rotations, POST, then hold in DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = i_valid ? PRE : IDLE;
      PRE: state_nx = ROT;
      ROT: state_nx = last ? POST : ROT;
      POST: state_nx = DONE;
      DONE: state_nx = i_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath: capture, pre-scale, shared add/sub micro-rotation, quadrant map and round
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      mag <= '0;
      phase <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
      k <= '0;
      o_i <= '0;
      o_q <= '0;
    end else begin
      if (state == IDLE && i_valid) begin
        mag <= i_mag > WIDTH'(SMAX) ? (WIDTH-1)'(SMAX) : i_mag[WIDTH-2:0];
        phase <= i_phase;
      end
      if (state == PRE) begin
        x <= x_pre;
        y <= '0;
        z <= z_pre;
        k <= '0;
      end
      if (state == ROT) begin
        x <= dir_pos ? x - y_sh : x + y_sh;
        y <= dir_pos ? y + x_sh : y - x_sh;
        z <= dir_pos ? z - atan_k : z + atan_k;
        k <= k + 5'd1;
      end
      if (state == POST) begin
        o_i <= sat(ri);
        o_q <= sat(rq);
      end
    end
endmodule

// File: tb/tb_polar_to_cmplx.sv
// tb_polar_to_cmplx: table vectors, handshake corner cases and a random sweep against a cos/sin model
module tb_polar_to_cmplx;
  localparam int WIDTH = 10;
  localparam int PHASE_W = 12;
  localparam int ITER = 12;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;
  logic [WIDTH-1:0] i_mag = '0;
  logic [PHASE_W-1:0] i_phase = '0;
  logic o_ready, o_valid;
  logic [WIDTH-1:0] o_i, o_q;
  int checks = 0;
  int failures = 0;
  typedef struct {int ei; int eq; int tol;} exp_t;
  typedef struct {logic [9:0] mag; logic [11:0] phase; int ei; int eq; int tol;} vec_t;
  exp_t sb[$];
  vec_t vecs[10];

  polar_to_cmplx #(.WIDTH(WIDTH), .PHASE_W(PHASE_W), .ITER(ITER)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mag(i_mag), .i_phase(i_phase), .i_valid(i_valid),
    .o_ready(o_ready), .o_i(o_i), .o_q(o_q), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req, input int tol);
    checks++;
    if (act > req + tol || act < req - tol) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, req, tol);
    end
  endtask

  function automatic int clip(input int v);
    return v > 511 ? 511 : v < -511 ? -511 : v;
  endfunction

  function automatic exp_t model(input logic [9:0] m, input logic [11:0] p);
    exp_t e;
    real a;
    int mc;
    a = 2.0 * 3.14159265358979 * real'(p) / 4096.0;
    mc = m > 10'd511 ? 511 : int'(m);
    e.ei = clip(int'($floor(real'(mc) * $cos(a) + 0.5)));
    e.eq = clip(int'($floor(real'(mc) * $sin(a) + 0.5)));
    e.tol = mc == 0 ? 0 : 2;
    return e;
  endfunction

  function automatic int si(input logic [WIDTH-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic send(input logic [9:0] m, input logic [11:0] p, input exp_t e);
    int n = 0;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("ready_wait", int'(o_ready), 1, 0);
    i_mag = m;
    i_phase = p;
    i_valid = 1'b1;
    sb.push_back(e);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_mag = 10'($urandom);
    i_phase = 12'($urandom);
  endtask

  task automatic wait_valid(output int m);
    m = 0;
    while (!o_valid && m < 100) begin
      @(negedge i_clk);
      m++;
    end
    if (!o_valid) chk("valid_timeout", 0, 1, 0);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_scoreboard_empty"}, 0, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({name, "_i"}, si(o_i), e.ei, e.tol);
    chk({name, "_q"}, si(o_q), e.eq, e.tol);
  endtask

  task automatic ack(input string name);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk({name, "_valid_drop"}, int'(o_valid), 0, 0);
    chk({name, "_ready_back"}, int'(o_ready), 1, 0);
  endtask

  initial begin
    int m, vi, vq, got, t0, t1, n;
    logic [9:0] rm;
    logic [11:0] rp;
    vecs = '{
      '{10'd300, 12'd0, 300, 0, 2},
      '{10'd300, 12'd1024, 0, 300, 2},
      '{10'd300, 12'd2048, -300, 0, 2},
      '{10'd300, 12'd3072, 0, -300, 2},
      '{10'd300, 12'd512, 212, 212, 2},
      '{10'd0, 12'd1234, 0, 0, 0},
      '{10'd0, 12'd3000, 0, 0, 0},
      '{10'd1023, 12'd0, 511, 0, 2},
      '{10'd511, 12'd3584, 361, -361, 2},
      '{10'd511, 12'd1536, -361, 361, 2}
    };
    repeat (3) @(negedge i_clk);
    chk("rst_valid", int'(o_valid), 0, 0);
    chk("rst_i", si(o_i), 0, 0);
    chk("rst_q", si(o_q), 0, 0);
    chk("rst_ready", int'(o_ready), 1, 0);
    i_rst = 1'b0;
    for (int v = 0; v < 10; v++) begin
      send(vecs[v].mag, vecs[v].phase, '{vecs[v].ei, vecs[v].eq, vecs[v].tol});
      wait_valid(m);
      chk($sformatf("vec%0d_latency", v), m + 1, ITER + 3, 0);
      pop_check($sformatf("vec%0d", v));
      ack($sformatf("vec%0d", v));
    end
    send(10'd511, 12'd3584, '{361, -361, 2});
    repeat (4) begin
      i_valid = 1'b1;
      i_mag = 10'd100;
      i_phase = 12'd0;
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
    end
    wait_valid(m);
    vi = si(o_i);
    vq = si(o_q);
    pop_check("bp");
    for (int c = 0; c < 10; c++) begin
      i_valid = c[0];
      i_mag = 10'd50;
      @(negedge i_clk);
      chk("bp_hold_i", si(o_i), vi, 0);
      chk("bp_hold_q", si(o_q), vq, 0);
      chk("bp_hold_valid", int'(o_valid), 1, 0);
      chk("bp_hold_ready", int'(o_ready), 0, 0);
    end
    i_valid = 1'b0;
    ack("bp");
    chk("bp_keep_i", si(o_i), vi, 0);
    chk("bp_keep_q", si(o_q), vq, 0);
    repeat (20) @(negedge i_clk);
    chk("bp_no_extra_valid", int'(o_valid), 0, 0);
    chk("bp_scoreboard_drained", sb.size(), 0, 0);
    send(10'd300, 12'd1024, '{0, 300, 2});
    repeat (6) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_valid", int'(o_valid), 0, 0);
    chk("midrst_i", si(o_i), 0, 0);
    chk("midrst_q", si(o_q), 0, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("midrst_ready", int'(o_ready), 1, 0);
    repeat (20) @(negedge i_clk);
    chk("midrst_no_partial", int'(o_valid), 0, 0);
    send(10'd300, 12'd1024, '{0, 300, 2});
    wait_valid(m);
    chk("after_rst_latency", m + 1, ITER + 3, 0);
    pop_check("after_rst");
    ack("after_rst");
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_mag = 10'd300;
    i_phase = 12'd2048;
    sb.push_back(model(10'd300, 12'd2048));
    sb.push_back(model(10'd300, 12'd2048));
    got = 0;
    t0 = 0;
    t1 = 0;
    n = 0;
    while (got < 2 && n < 100) begin
      @(negedge i_clk);
      n++;
      if (o_valid) begin
        if (got == 0) t0 = n;
        else t1 = n;
        got++;
        pop_check("tput");
        if (got == 2) i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("tput_count", got, 2, 0);
    chk("tput_period", t1 - t0, ITER + 4, 0);
    for (int r = 0; r < 2000; r++) begin
      rm = 10'($urandom_range(0, 1023));
      rp = 12'($urandom);
      send(rm, rp, model(rm, rp));
      wait_valid(m);
      pop_check($sformatf("rnd_m%0d_p%0d", rm, rp));
      ack("rnd");
    end
    chk("final_scoreboard_empty", sb.size(), 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
